// File: rtl/intra_line_ram_arbiter.sv
// Line RAM arbiter for intra prediction: requester A (intra-pred FSM) owns the
// luma/Cb/Cr line RAMs whenever it asks; requester B gets bounded bursts in the
// gaps, with a one-cycle read return taken straight from the selected bank.
//
// Handshake: B holds b_req (with b_wr/b_sel/b_addr/b_wdata stable) until it sees
// b_gnt high in the same cycle; that cycle is the transfer. A granted read is
// answered by exactly one b_rvalid pulse on the following cycle; writes have no
// response. b_gnt is combinational and never depends on b_rvalid.
module intra_line_ram_arbiter #(
    parameter int MB_X_BITS    = 7,
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_req,
    input  logic [MB_X_BITS+1:0] a_luma_addr,
    input  logic [MB_X_BITS:0]   a_chroma_addr,
    input  logic                 a_luma_wr_n,
    input  logic                 a_cb_wr_n,
    input  logic                 a_cr_wr_n,
    input  logic [31:0]          a_wdata,
    input  logic                 b_req,
    input  logic                 b_wr,
    input  logic [1:0]           b_sel,
    input  logic [MB_X_BITS+1:0] b_addr,
    input  logic [31:0]          b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [31:0]          b_rdata,
    output logic                 b_starved,
    output logic                 b_err,
    output logic [MB_X_BITS+1:0] ram_luma_addr,
    output logic [MB_X_BITS:0]   ram_chroma_addr,
    output logic                 ram_luma_wr_n,
    output logic                 ram_cb_wr_n,
    output logic                 ram_cr_wr_n,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_luma_rdata,
    input  logic [31:0]          ram_cb_rdata,
    input  logic [31:0]          ram_cr_rdata,
    output logic [1:0]           dbg_state
);

    localparam logic [3:0] MAX_B   = 4'(MAX_BURST);
    localparam logic [7:0] S_LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [3:0]           burst_cnt, burst_cnt_nxt;
    logic [7:0]           starve_cnt, starve_cnt_nxt;
    logic                 rvalid_q;
    logic [1:0]           rsel_q;
    logic [31:0]          rdata_q;
    logic [MB_X_BITS+1:0] luma_addr_q;
    logic [MB_X_BITS:0]   chroma_addr_q;
    logic [31:0]          wdata_q;

    assign dbg_state = state;
    assign b_rvalid  = rvalid_q;

    // Grant: A always wins, no grant in the forced release cycle or for bank 3.
    assign b_gnt = rst_n & b_req & ~a_req & (state != RELEASE) & (b_sel != 2'd3);

    // Burst FSM next state: count grants, force a release after MAX_BURST.
    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (b_gnt) begin
                    if (MAX_B == 4'd1) begin
                        state_nxt     = RELEASE;
                        burst_cnt_nxt = 4'd0;
                    end else begin
                        state_nxt     = BURST;
                        burst_cnt_nxt = 4'd1;
                    end
                end
            end
            BURST: begin
                if (b_gnt) begin
                    if (burst_cnt + 4'd1 == MAX_B) begin
                        state_nxt     = RELEASE;
                        burst_cnt_nxt = 4'd0;
                    end else begin
                        burst_cnt_nxt = burst_cnt + 4'd1;
                    end
                end else if (!b_req || a_req) begin
                    state_nxt     = IDLE;
                    burst_cnt_nxt = 4'd0;
                end
            end
            RELEASE: begin
                state_nxt     = IDLE;
                burst_cnt_nxt = 4'd0;
            end
            default: begin
                state_nxt     = IDLE;
                burst_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Burst FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // RAM port mux: A passes through, granted B drives its bank, otherwise
    // strobes idle and address/data hold their last driven values.
    always_comb begin
        ram_luma_addr   = luma_addr_q;
        ram_chroma_addr = chroma_addr_q;
        ram_wdata       = wdata_q;
        ram_luma_wr_n   = 1'b1;
        ram_cb_wr_n     = 1'b1;
        ram_cr_wr_n     = 1'b1;
        if (!rst_n) begin
            ram_luma_wr_n = 1'b1;
        end else if (a_req) begin
            ram_luma_addr   = a_luma_addr;
            ram_chroma_addr = a_chroma_addr;
            ram_wdata       = a_wdata;
            ram_luma_wr_n   = a_luma_wr_n;
            ram_cb_wr_n     = a_cb_wr_n;
            ram_cr_wr_n     = a_cr_wr_n;
        end else if (b_gnt) begin
            ram_luma_addr   = b_addr;
            ram_chroma_addr = b_addr[MB_X_BITS:0];
            ram_wdata       = b_wdata;
            case (b_sel)
                2'd0:    ram_luma_wr_n = ~b_wr;
                2'd1:    ram_cb_wr_n   = ~b_wr;
                2'd2:    ram_cr_wr_n   = ~b_wr;
                default: ram_luma_wr_n = 1'b1;
            endcase
        end
    end

    // Hold registers for the RAM address/data bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luma_addr_q   <= '0;
            chroma_addr_q <= '0;
            wdata_q       <= '0;
        end else begin
            luma_addr_q   <= ram_luma_addr;
            chroma_addr_q <= ram_chroma_addr;
            wdata_q       <= ram_wdata;
        end
    end

    // Read return data: selected bank while valid, otherwise the last value.
    always_comb begin
        b_rdata = rdata_q;
        if (rvalid_q) begin
            case (rsel_q)
                2'd0:    b_rdata = ram_luma_rdata;
                2'd1:    b_rdata = ram_cb_rdata;
                2'd2:    b_rdata = ram_cr_rdata;
                default: b_rdata = rdata_q;
            endcase
        end
    end

    // Read-return pipeline: capture grant-time bank select, hold returned data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rsel_q   <= 2'd0;
            rdata_q  <= 32'd0;
        end else begin
            rvalid_q <= b_gnt & ~b_wr;
            if (b_gnt) rsel_q <= b_sel;
            rdata_q  <= b_rdata;
        end
    end

    // Starvation counter: consecutive pending-but-ungranted cycles, saturating.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!b_req || b_gnt)          starve_cnt_nxt = 8'd0;
        else if (starve_cnt != S_LIMIT) starve_cnt_nxt = starve_cnt + 8'd1;
    end

    // Sticky status flags and the starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 8'd0;
            b_starved  <= 1'b0;
            b_err      <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            if (starve_cnt_nxt == S_LIMIT) b_starved <= 1'b1;
            if (b_req && b_sel == 2'd3)    b_err     <= 1'b1;
        end
    end

endmodule
